// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative RV64M divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

  // Widest datapath the helpers support; callers size-cast in and out.
  localparam int MAX_W = 128;

  // Counter width for a given datapath width.
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

  // Replace x with the sign extension of its low w/2 bits (*W result fix-up).
  function automatic logic [MAX_W-1:0] sext_half(input logic [MAX_W-1:0] x, input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++)
      r[i] = (i < w/2) ? x[i] : x[w/2-1];
    return r;
  endfunction

endpackage

// File: rtl/div_prep.sv
// Operand preparation: *W extension, absolute values, result signs and
// RISC-V special-case detection with preloaded results.
module div_prep
  import div_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  input  logic             is_word,
  output logic [WIDTH-1:0] a_abs,
  output logic [WIDTH-1:0] b_abs,
  output logic             sign_q,
  output logic             sign_r,
  output logic             special,
  output logic [WIDTH-1:0] spec_q,
  output logic [WIDTH-1:0] spec_r
);
  localparam int H = WIDTH / 2;

  logic [WIDTH-1:0] a_ext, b_ext;
  logic             neg_a, neg_b, div0, ovf;

  always_comb begin
    a_ext = dividend;
    b_ext = divisor;
    if (is_word) begin
      a_ext = {{H{is_signed & dividend[H-1]}}, dividend[H-1:0]};
      b_ext = {{H{is_signed & divisor[H-1]}},  divisor[H-1:0]};
    end
    neg_a  = is_signed & a_ext[WIDTH-1];
    neg_b  = is_signed & b_ext[WIDTH-1];
    // Most-negative value negates to itself, which reads correctly as unsigned.
    a_abs  = neg_a ? -a_ext : a_ext;
    b_abs  = neg_b ? -b_ext : b_ext;
    sign_q = neg_a ^ neg_b;
    sign_r = neg_a;
    div0   = (b_ext == '0);
    ovf    = is_signed && (a_ext == {1'b1, {(WIDTH-1){1'b0}}}) && (b_ext == '1);
    special = div0 | ovf;
    spec_q = div0 ? '1 : a_ext;
    spec_r = div0 ? a_ext : '0;
  end

endmodule

// File: rtl/divider.sv
// Radix-2 restoring divider for RV64M DIV/REM families, one quotient bit
// per cycle, valid/ready on both sides, flushable.
module divider
  import div_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  input  logic             is_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CNT_W = cnt_w(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic             sgn_q_q, sgn_q_d, sgn_r_q, sgn_r_d, word_q, word_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;

  logic [WIDTH-1:0] p_a_abs, p_b_abs, p_spec_q, p_spec_r;
  logic             p_sign_q, p_sign_r, p_special;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] r_sub, r_nxt, q_nxt, q_fin, r_fin;
  logic             ge;

  div_prep #(.WIDTH(WIDTH)) u_prep (
    .dividend (dividend),
    .divisor  (divisor),
    .is_signed(is_signed),
    .is_word  (is_word),
    .a_abs    (p_a_abs),
    .b_abs    (p_b_abs),
    .sign_q   (p_sign_q),
    .sign_r   (p_sign_r),
    .special  (p_special),
    .spec_q   (p_spec_q),
    .spec_r   (p_spec_r)
  );

  function automatic logic [WIDTH-1:0] word_fix(input logic [WIDTH-1:0] x, input logic w);
    return w ? WIDTH'(sext_half(MAX_W'(x), WIDTH)) : x;
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

  always_comb begin
    // Partial remainder is WIDTH+1 bits; after a subtract it always fits WIDTH.
    r_sh  = {rem_q, quo_q[WIDTH-1]};
    ge    = (r_sh >= {1'b0, dvs_q});
    r_sub = r_sh[WIDTH-1:0] - dvs_q;
    r_nxt = ge ? r_sub : r_sh[WIDTH-1:0];
    q_nxt = {quo_q[WIDTH-2:0], ge};
    q_fin = word_fix(sgn_q_q ? -q_nxt : q_nxt, word_q);
    r_fin = word_fix(sgn_r_q ? -r_nxt : r_nxt, word_q);

    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    sgn_q_d     = sgn_q_q;
    sgn_r_d     = sgn_r_q;
    word_d      = word_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      IDLE: if (in_valid) begin
        if (p_special) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          quotient_d  = word_fix(p_spec_q, is_word);
          remainder_d = word_fix(p_spec_r, is_word);
        end else begin
          state_d = BUSY;
          cnt_d   = CNT_W'(WIDTH-1);
          rem_d   = '0;
          quo_d   = p_a_abs;
          dvs_d   = p_b_abs;
          sgn_q_d = p_sign_q;
          sgn_r_d = p_sign_r;
          word_d  = is_word;
        end
      end
      BUSY: begin
        rem_d = r_nxt;
        quo_d = q_nxt;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          quotient_d  = q_fin;
          remainder_d = r_fin;
        end
      end
      DONE: if (out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      sgn_q_q     <= 1'b0;
      sgn_r_q     <= 1'b0;
      word_q      <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      sgn_q_q     <= sgn_q_d;
      sgn_r_q     <= sgn_r_d;
      word_q      <= word_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

endmodule
